// File: rtl/dsdac_pkg.sv
// Shared definitions for the delta-sigma DAC stream controller:
// sequencer state encoding, midscale helper and ramp slew helper.
package dsdac_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // Midscale code of an n-bit excess-2^(n-1) sample.
  function automatic logic [31:0] midscale(input int unsigned n);
    return 32'd1 << (n - 1);
  endfunction

  // Move x toward t by at most step. Operands are zero-extended samples,
  // so the wide intermediate never wraps and never overshoots t.
  function automatic logic [31:0] slew(input logic [31:0] x,
                                       input logic [31:0] t,
                                       input logic [31:0] step);
    logic [31:0] res;
    if (t >= x) begin
      res = ((t - x) <= step) ? t : (x + step);
    end else begin
      res = ((x - t) <= step) ? t : (x - step);
    end
    return res;
  endfunction

endpackage

// File: rtl/dsdac_nco.sv
// Phase-accumulator NCO: the accumulator carry, registered, becomes a
// one-clock tick. A zero increment never ticks.
module dsdac_nco #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] tune,
  output logic             tick
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_reg} + {1'b0, tune};

  // Accumulate the increment; the carry out is the next tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= '0;
      tick    <= 1'b0;
    end else begin
      acc_reg <= sum[ACC_W-1:0];
      tick    <= sum[ACC_W];
    end
  end

endmodule

// File: rtl/dsdac_stream_ctrl.sv
// Stream sequencer for the delta-sigma DAC: NCO tick generation, divide
// to sample strobe, one handshake pull per strobe, soft start/stop ramps
// around midscale and a sticky underrun flag.
module dsdac_stream_ctrl
  import dsdac_pkg::*;
#(
  parameter int N         = 8,
  parameter int ACC_W     = 16,
  parameter int OSR_LOG2  = 6,
  parameter int RAMP_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ACC_W-1:0] tune,
  input  logic [N-1:0]     s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             clr_underrun,
  output logic [N-1:0]     dac_in,
  output logic             dac_nco,
  output logic             underrun,
  output logic             busy
);

  localparam logic [N-1:0] MID = N'(midscale(N));

  logic                tick;
  logic [OSR_LOG2-1:0] tick_cnt_reg;
  logic                strobe;
  logic                take;
  logic                starve;
  logic [N-1:0]        held_after;
  logic [N-1:0]        slewed;

  state_t              state_reg, state_next;
  logic [N-1:0]        dac_in_reg, dac_in_next;
  logic [N-1:0]        held_reg, held_next;
  logic                underrun_reg;

  dsdac_nco #(.ACC_W(ACC_W)) u_nco (
    .clk   (clk),
    .reset (reset),
    .tune  (tune),
    .tick  (tick)
  );

  // Count modulator ticks; the last tick of each group is the sample strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= tick_cnt_reg + OSR_LOG2'(1);
    end
  end

  assign strobe     = tick && (&tick_cnt_reg);
  assign s_ready    = strobe && ((state_reg == RAMP_UP) || (state_reg == RUN));
  assign take       = s_ready && s_valid;
  assign starve     = s_ready && !s_valid;
  assign held_after = take ? s_data : held_reg;

  // Next state, next DAC value and held sample; enable acts immediately,
  // the DAC value only moves on strobes.
  always_comb begin
    state_next  = state_reg;
    dac_in_next = dac_in_reg;
    held_next   = held_after;
    slewed      = dac_in_reg;
    case (state_reg)
      IDLE: begin
        dac_in_next = MID;
        if (enable) state_next = RAMP_UP;
      end
      RAMP_UP: begin
        slewed = N'(slew(32'(dac_in_reg), 32'(held_after), 32'(RAMP_STEP)));
        if (strobe) dac_in_next = slewed;
        if (!enable) begin
          state_next = RAMP_DOWN;
        end else if (strobe && (slewed == held_after)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (strobe) dac_in_next = held_after;
        if (!enable) state_next = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        slewed = N'(slew(32'(dac_in_reg), 32'(MID), 32'(RAMP_STEP)));
        if (strobe) dac_in_next = slewed;
        if (enable) begin
          state_next = RAMP_UP;
        end else if (strobe && (slewed == MID)) begin
          state_next = IDLE;
          held_next  = MID;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      dac_in_reg <= MID;
      held_reg   <= MID;
    end else begin
      state_reg  <= state_next;
      dac_in_reg <= dac_in_next;
      held_reg   <= held_next;
    end
  end

  // Sticky underrun: a new underrun outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_reg <= 1'b0;
    end else if (starve) begin
      underrun_reg <= 1'b1;
    end else if (clr_underrun) begin
      underrun_reg <= 1'b0;
    end
  end

  assign dac_in   = dac_in_reg;
  assign dac_nco  = tick;
  assign underrun = underrun_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_dsdac_stream_ctrl.sv
// Self-checking bench for dsdac_stream_ctrl (N=8, ACC_W=16, OSR_LOG2=2,
// RAMP_STEP=16): per-cycle comparison against a behavioural model plus
// directed literal expectations.
module tb_dsdac_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] tune;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        clr_underrun;
  logic [7:0]  dac_in;
  logic        dac_nco;
  logic        underrun;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state (plain integers, mode 0=idle 1=ramp up 2=run 3=ramp down)
  int m_acc, m_cnt, m_mode, m_dac, m_held;
  bit m_nco, m_unr;

  int rec[8];
  int sr_seen;

  dsdac_stream_ctrl #(.N(8), .ACC_W(16), .OSR_LOG2(2), .RAMP_STEP(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .tune         (tune),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .clr_underrun (clr_underrun),
    .dac_in       (dac_in),
    .dac_nco      (dac_nco),
    .underrun     (underrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ramp move: clamp the distance to the target into [-16, 16].
  function automatic int step_toward(int x, int t);
    int d;
    d = t - x;
    if (d > 16) d = 16;
    if (d < -16) d = -16;
    return x + d;
  endfunction

  // Behavioural model, advanced on the same edge as the DUT.
  always @(posedge clk) begin
    if (reset) begin
      m_acc = 0; m_nco = 0; m_cnt = 0; m_mode = 0;
      m_dac = 128; m_held = 128; m_unr = 0;
    end else begin : mdl
      bit stb, pull;
      int h, sum;
      stb  = m_nco && (m_cnt == 3);
      pull = stb && (m_mode == 1 || m_mode == 2);
      h    = (pull && s_valid) ? int'(s_data) : m_held;
      if (pull && !s_valid) m_unr = 1;
      else if (clr_underrun) m_unr = 0;
      m_held = h;
      case (m_mode)
        0: if (enable) m_mode = 1;
        1: begin
          if (stb) m_dac = step_toward(m_dac, h);
          if (!enable) m_mode = 3;
          else if (stb && m_dac == h) m_mode = 2;
        end
        2: begin
          if (stb) m_dac = h;
          if (!enable) m_mode = 3;
        end
        default: begin
          if (stb) m_dac = step_toward(m_dac, 128);
          if (enable) m_mode = 1;
          else if (stb && m_dac == 128) begin
            m_mode = 0;
            m_held = 128;
          end
        end
      endcase
      if (m_nco) m_cnt = (m_cnt + 1) % 4;
      sum   = m_acc + int'(tune);
      m_nco = (sum >= 65536);
      m_acc = sum % 65536;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dac_in",   int'(dac_in),   m_dac);
      chk("dac_nco",  int'(dac_nco),  int'(m_nco));
      chk("s_ready",  int'(s_ready),  int'(m_nco && m_cnt == 3 && (m_mode == 1 || m_mode == 2)));
      chk("underrun", int'(underrun), int'(m_unr));
      chk("busy",     int'(busy),     int'(m_mode != 0));
    end
  end

  // Record the next n distinct dac_in values, counting s_ready pulses.
  task automatic collect(input int n);
    int prev, got, cyc;
    prev = int'(dac_in); got = 0; cyc = 0; sr_seen = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (s_ready) sr_seen++;
      if (int'(dac_in) != prev) begin
        rec[got] = int'(dac_in);
        $display("tb: dac_in -> 0x%02h (busy=%0b underrun=%0b)", dac_in, busy, underrun);
        got++;
        prev = int'(dac_in);
      end
    end
    chk("collect_count", got, n);
  endtask

  task automatic wait_dac(input int target);
    int cyc;
    cyc = 0;
    while (int'(dac_in) != target && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_dac", int'(dac_in), target);
  endtask

  task automatic wait_sready();
    int cyc;
    cyc = 0;
    while (!s_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_sready", int'(s_ready), 1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_dac_in"},   int'(dac_in),   8'h80);
    chk({tag, "_dac_nco"},  int'(dac_nco),  0);
    chk({tag, "_s_ready"},  int'(s_ready),  0);
    chk({tag, "_underrun"}, int'(underrun), 0);
    chk({tag, "_busy"},     int'(busy),     0);
  endtask

  initial begin : stim
    int cnt, gap;
    // reset with random inputs
    reset = 1'b1;
    enable = 1'($urandom); tune = 16'($urandom); s_data = 8'($urandom);
    s_valid = 1'($urandom); clr_underrun = 1'($urandom);
    @(negedge clk);
    chk_en = 1'b1;
    reset_checks("reset");
    $display("tb: reset released");
    reset = 1'b0; enable = 1'b0; tune = 16'h8000; s_data = 8'h00;
    s_valid = 1'b0; clr_underrun = 1'b0;

    // NCO at half rate: one tick every second clock
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (dac_nco) cnt++;
    end
    chk("nco_half_rate_ticks", cnt, 8);
    $display("tb: nco tune=0x8000 ticks in 16 clks = %0d", cnt);

    // tune = 0 never ticks
    tune = 16'h0000;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dac_nco) cnt++;
    end
    chk("nco_zero_ticks", cnt, 0);
    $display("tb: nco tune=0 ticks in 100 clks = %0d", cnt);

    // quarter rate briefly (model follows), then back to half rate
    tune = 16'h4000;
    repeat (40) @(negedge clk);
    tune = 16'h8000;

    // soft start toward 0xC0
    s_valid = 1'b1; s_data = 8'hC0; enable = 1'b1;
    collect(4);
    chk("start_0", rec[0], 8'h90);
    chk("start_1", rec[1], 8'hA0);
    chk("start_2", rec[2], 8'hB0);
    chk("start_3", rec[3], 8'hC0);
    chk("start_busy", int'(busy), 1);

    // sample strobe period is 8 clocks
    wait_sready();
    @(negedge clk);
    gap = 1;
    while (!s_ready && gap < 30) begin
      @(negedge clk);
      gap++;
    end
    chk("strobe_period", gap, 8);
    chk("run_dac", int'(dac_in), 8'hC0);

    // underrun: repeat last sample, sticky flag
    s_valid = 1'b0;
    @(negedge clk);
    wait_sready();
    @(negedge clk);
    chk("underrun_set", int'(underrun), 1);
    chk("underrun_hold", int'(dac_in), 8'hC0);
    $display("tb: underrun flagged, dac_in=0x%02h", dac_in);
    wait_sready();
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    chk("underrun_set_wins", int'(underrun), 1);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    chk("underrun_cleared", int'(underrun), 0);
    $display("tb: underrun cleared");

    // soft stop from 0x40
    s_valid = 1'b1; s_data = 8'h40;
    wait_dac(8'h40);
    enable = 1'b0;
    collect(4);
    chk("stop_0", rec[0], 8'h50);
    chk("stop_1", rec[1], 8'h60);
    chk("stop_2", rec[2], 8'h70);
    chk("stop_3", rec[3], 8'h80);
    chk("stop_no_ready", sr_seen, 0);
    chk("stop_idle", int'(busy), 0);

    // ramp back to 0x40, then re-enable mid ramp-down at 0x60
    enable = 1'b1;
    wait_dac(8'h40);
    enable = 1'b0;
    wait_dac(8'h60);
    enable = 1'b1; s_data = 8'hA0;
    collect(4);
    chk("reen_0", rec[0], 8'h70);
    chk("reen_1", rec[1], 8'h80);
    chk("reen_2", rec[2], 8'h90);
    chk("reen_3", rec[3], 8'hA0);

    // reset mid-run with underrun set
    s_data = 8'hC0;
    wait_dac(8'hC0);
    s_valid = 1'b0;
    @(negedge clk);
    wait_sready();
    @(negedge clk);
    chk("pre_reset_underrun", int'(underrun), 1);
    reset = 1'b1;
    @(negedge clk);
    reset_checks("midreset");
    $display("tb: mid-run reset applied");
    reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
